// File: rtl/fetch_align_buffer.sv
// Instruction fetch alignment buffer: turns a stream of 32-bit memory words into
// whole 16-bit or 32-bit instructions, including instructions that straddle words.
module fetch_align_buffer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] imem_data_i,
    input  logic        imem_valid_i,
    output logic        imem_ready_o,
    output logic [31:0] fetch_addr_o,
    input  logic        flush_i,
    input  logic [31:0] flush_pc_i,
    output logic [31:0] out_inst_o,
    output logic [31:0] out_pc_o,
    output logic        out_is_comp_o,
    output logic        out_valid_o,
    input  logic        out_ready_i
);

    logic [2:0][15:0] hw_q, hw_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [31:0]      faddr_q, faddr_d;
    logic [31:0]      pc_q, pc_d;
    logic             drop_q, drop_d;

    logic             hw0_comp, push, pop;
    logic [1:0]       npush, npop, rem, j;
    logic [4:0][15:0] ext;
    logic [1:0][15:0] pw;

    always_comb begin
        hw0_comp      = (hw_q[0][1:0] != 2'b11);
        out_valid_o   = !flush_i && (hw0_comp ? (cnt_q >= 2'd1) : (cnt_q >= 2'd2));
        imem_ready_o  = !flush_i && (cnt_q <= 2'd1);
        out_inst_o    = hw0_comp ? {16'h0, hw_q[0]} : {hw_q[1], hw_q[0]};
        out_is_comp_o = hw0_comp;
        out_pc_o      = pc_q;
        fetch_addr_o  = faddr_q;
    end

    always_comb begin
        push  = imem_valid_i && imem_ready_o;
        pop   = out_valid_o && out_ready_i;
        npush = push ? (drop_q ? 2'd1 : 2'd2) : 2'd0;
        npop  = pop ? (hw0_comp ? 2'd1 : 2'd2) : 2'd0;
        rem   = cnt_q - npop;
        ext   = {32'h0, hw_q};
        // After a redirect to an odd halfword, only the upper half of the first word is kept.
        pw    = drop_q ? {16'h0, imem_data_i[31:16]} : imem_data_i;
        j     = '0;
        hw_d  = hw_q;
        // Survivors shift down by the popped amount; new halfwords land right behind them.
        for (int i = 0; i < 3; i++) begin
            j = 2'(i) - rem;
            if (2'(i) < rem)
                hw_d[i] = ext[3'(i) + {1'b0, npop}];
            else if (j < npush)
                hw_d[i] = pw[j[0]];
        end
        cnt_d   = rem + npush;
        faddr_d = push ? faddr_q + 32'd4 : faddr_q;
        pc_d    = pop ? pc_q + (hw0_comp ? 32'd2 : 32'd4) : pc_q;
        drop_d  = push ? 1'b0 : drop_q;
        if (flush_i) begin
            cnt_d   = 2'd0;
            faddr_d = {flush_pc_i[31:2], 2'b00};
            pc_d    = {flush_pc_i[31:1], 1'b0};
            drop_d  = flush_pc_i[1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= 2'd0;
            faddr_q <= {RESET_PC[31:2], 2'b00};
            pc_q    <= {RESET_PC[31:1], 1'b0};
            drop_q  <= RESET_PC[1];
        end else begin
            cnt_q   <= cnt_d;
            faddr_q <= faddr_d;
            pc_q    <= pc_d;
            drop_q  <= drop_d;
        end
    end

    // Halfword storage is qualified by cnt_q, so it carries no reset.
    always_ff @(posedge clk) begin
        hw_q <= hw_d;
    end

endmodule

// File: tb/tb_fetch_align_buffer.sv
// Scoreboard bench for fetch_align_buffer: a small memory feeds words, the bench
// parses the same halfword stream to predict every instruction, pc and length.
module tb_fetch_align_buffer;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] imem_data_i;
    logic        imem_valid_i;
    logic        imem_ready_o;
    logic [31:0] fetch_addr_o;
    logic        flush_i;
    logic [31:0] flush_pc_i;
    logic [31:0] out_inst_o;
    logic [31:0] out_pc_o;
    logic        out_is_comp_o;
    logic        out_valid_o;
    logic        out_ready_i;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        comp;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mem [0:63];
    logic [31:0] end_addr;
    logic        feed_en, vbit;
    int          n_chk = 0, n_err = 0;

    fetch_align_buffer #(.RESET_PC(RESET_PC)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_data_i  (imem_data_i),
        .imem_valid_i (imem_valid_i),
        .imem_ready_o (imem_ready_o),
        .fetch_addr_o (fetch_addr_o),
        .flush_i      (flush_i),
        .flush_pc_i   (flush_pc_i),
        .out_inst_o   (out_inst_o),
        .out_pc_o     (out_pc_o),
        .out_is_comp_o(out_is_comp_o),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i)
    );

    always #5 clk = ~clk;

    assign imem_data_i  = mem[fetch_addr_o[7:2]];
    assign imem_valid_i = feed_en && vbit && (fetch_addr_o != end_addr);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] hwat(input logic [31:0] a);
        logic [31:0] w;
        w = mem[a[7:2]];
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    // Reference parse of the halfword stream from spc up to (not past) end_addr.
    task automatic gen(input logic [31:0] spc);
        logic [31:0] p;
        logic [15:0] h;
        p = {spc[31:1], 1'b0};
        while (p + 2 <= end_addr) begin
            h = hwat(p);
            if (h[1:0] != 2'b11) begin
                sb.push_back('{inst: {16'h0, h}, pc: p, comp: 1'b1});
                p += 2;
            end else begin
                if (p + 4 > end_addr) break;
                sb.push_back('{inst: {hwat(p + 2), h}, pc: p, comp: 1'b0});
                p += 4;
            end
        end
    endtask

    // Monitor: sampled on the falling edge, so the handshake seen here fires at the next rise.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid_o && out_ready_i) begin
            if (sb.size() == 0) begin
                chk("unexpected_out", out_inst_o, 32'hxxxx_xxxx);
            end else begin
                e = sb.pop_front();
                chk("inst", out_inst_o, e.inst);
                chk("pc", out_pc_o, e.pc);
                chk("comp", {31'h0, out_is_comp_o}, {31'h0, e.comp});
            end
        end
    end

    task automatic start(input logic [31:0] spc, input int nwords);
        sb.delete();
        feed_en  = 1'b0;
        end_addr = {spc[31:2], 2'b00} + 32'(4 * nwords);
        gen(spc);
        @(posedge clk); #1;
        flush_i = 1'b1; flush_pc_i = spc;
        @(posedge clk); #1;
        flush_i = 1'b0;
        chk("flush_faddr", fetch_addr_o, {spc[31:2], 2'b00});
        chk("flush_pc", out_pc_o, {spc[31:1], 1'b0});
        feed_en = 1'b1;
    endtask

    task automatic drain(input int vpct, input int rpct);
        int cyc;
        cyc = 0;
        while ((sb.size() != 0 || fetch_addr_o != end_addr) && cyc < 2000) begin
            vbit        = ($urandom_range(99) < vpct);
            out_ready_i = ($urandom_range(99) < rpct);
            @(posedge clk); #1;
            cyc++;
        end
        chk("drained", 32'(sb.size()), 32'd0);
        chk("end_faddr", fetch_addr_o, end_addr);
        feed_en = 1'b0; out_ready_i = 1'b0; vbit = 1'b0;
    endtask

    initial begin
        logic [31:0] held;
        foreach (mem[i]) mem[i] = 32'h0;
        rst_n = 1'b0; flush_i = 1'b0; flush_pc_i = 32'h0;
        out_ready_i = 1'b0; feed_en = 1'b0; vbit = 1'b0; end_addr = 32'h0;
        #1;
        chk("rst_valid", {31'h0, out_valid_o}, 32'h0);
        chk("rst_faddr", fetch_addr_o, RESET_PC);
        chk("rst_pc", out_pc_o, RESET_PC);
        #11 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rdy_post_rst", {31'h0, imem_ready_o}, 32'h1);

        // Single 32-bit instruction
        mem[0] = 32'h0013_0513;
        start(32'h0, 1);
        chk("exp_first", sb[0].inst, 32'h0013_0513);
        drain(100, 100);

        // Two compressed in one word
        mem[0] = 32'h4501_4505;
        start(32'h0, 1);
        drain(100, 100);

        // Straddling 32-bit instruction
        mem[0] = 32'h0513_0001; mem[1] = 32'h0001_0013;
        start(32'h0, 2);
        drain(70, 60);

        // Redirect to an odd halfword: low half of the first word must vanish
        mem[0] = 32'h4505_ABCD; mem[1] = 32'h0000_0000;
        start(32'h102, 1);
        drain(100, 100);

        // Decode stalled while memory keeps offering words
        mem[0] = 32'h0013_0513; mem[1] = 32'h0023_0593;
        mem[2] = 32'h4501_4505; mem[3] = 32'h0033_0613;
        start(32'h0, 4);
        vbit = 1'b1; out_ready_i = 1'b0;
        held = 32'h0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (c == 0) held = out_inst_o;
        end
        chk("stall_ready", {31'h0, imem_ready_o}, 32'h0);
        chk("stall_valid", {31'h0, out_valid_o}, 32'h1);
        chk("stall_inst", out_inst_o, 32'h0013_0513);
        chk("stall_stable", out_inst_o, held);
        drain(100, 100);

        // Reset pulse with two halfwords buffered
        mem[0] = 32'h0013_0513;
        start(32'h0, 4);
        vbit = 1'b1; out_ready_i = 1'b0;
        @(posedge clk); #1;
        vbit = 1'b0; feed_en = 1'b0;
        chk("pre_rst_valid", {31'h0, out_valid_o}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_valid", {31'h0, out_valid_o}, 32'h0);
        chk("midrst_faddr", fetch_addr_o, RESET_PC);
        sb.delete();
        @(negedge clk); rst_n = 1'b1; out_ready_i = 1'b1;
        @(posedge clk); #1;
        chk("rdy_after_rst", {31'h0, imem_ready_o}, 32'h1);
        chk("no_stale", {31'h0, out_valid_o}, 32'h0);
        repeat (3) @(posedge clk);
        #1 out_ready_i = 1'b0;

        // Random streams under random backpressure
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 64; i++) mem[i] = $urandom;
            start({24'h0, 2'b00, 5'($urandom_range(31)), 1'b0}, 12);
            drain(50 + 10 * r, 40 + 15 * r);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_align_buffer.md
FETCH_ALIGN_BUFFER -- requirements
Module: fetch_align_buffer

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h0000_0000, byte address of the first instruction after reset.
REQ-002 SHALL have port: clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port: imem_data_i  input  32  word-aligned instruction memory word for fetch_addr_o.
REQ-005 SHALL have port: imem_valid_i  input  1  imem_data_i is valid.
REQ-006 SHALL have port: imem_ready_o  output  1  buffer accepts a word this cycle.
REQ-007 SHALL have port: fetch_addr_o  output  32  word address currently requested; bits[1:0] always 00.
REQ-008 SHALL have port: flush_i  input  1  redirect request (branch, jump, trap).
REQ-009 SHALL have port: flush_pc_i  input  32  redirect target; bit 0 ignored.
REQ-010 SHALL have port: out_inst_o  output  32  aligned instruction to decode; a 16-bit parcel appears in [15:0] with [31:16]=0.
REQ-011 SHALL have port: out_pc_o  output  32  byte address of out_inst_o.
REQ-012 SHALL have port: out_is_comp_o  output  1  out_inst_o is a 16-bit parcel.
REQ-013 SHALL have port: out_valid_o  output  1  out_inst_o/out_pc_o/out_is_comp_o valid.
REQ-014 SHALL have port: out_ready_i  input  1  decode accepts the output this cycle.

Function
REQ-015 SHALL hold up to 3 halfwords (hw0 = oldest) with a 2-bit count (0..3).
REQ-016 SHALL classify hw0 as 16-bit when hw0[1:0]!=2'b11, otherwise as 32-bit; no other bits affect length.
REQ-017 SHALL assert out_valid_o when !flush_i and (count>=1 and hw0 is 16-bit, or count>=2 and hw0 is 32-bit).
REQ-018 SHALL drive out_inst_o={16'h0,hw0} for 16-bit and {hw1,hw0} for 32-bit; out_is_comp_o accordingly; outputs derive only from registers plus flush_i.
REQ-019 SHALL assert imem_ready_o when count<=1 and !flush_i; it SHALL NOT depend on out_ready_i.
REQ-020 SHALL push on imem_valid_i&&imem_ready_o: [15:0] then [31:16] appended behind existing halfwords; fetch_addr_o += 4.
REQ-021 SHALL discard imem_data_i[15:0] of the first word pushed after drop_lo is set, push only [31:16], then clear drop_lo.
REQ-022 SHALL pop on out_valid_o&&out_ready_i: 1 halfword for 16-bit, 2 for 32-bit; out_pc_o += 2 or 4.
REQ-023 SHALL apply push and pop in the same cycle as count_next=count+pushed-popped, remaining halfwords shifting toward hw0 in order.
REQ-024 SHALL, on flush_i (priority over push and pop that cycle): count<=0, fetch_addr_o<={flush_pc_i[31:2],2'b00}, out_pc_o<={flush_pc_i[31:1],1'b0}, drop_lo<=flush_pc_i[1].
REQ-025 SHALL treat a 32-bit instruction straddling two memory words as a normal case: it waits in hw0 until hw1 arrives, then is output whole.
REQ-026 SHALL wrap fetch_addr_o and out_pc_o modulo 2^32 without error indication.
REQ-027 SHALL not lose, duplicate or reorder halfwords under any out_ready_i/imem_valid_i pattern.

Reset
REQ-028 SHALL, while rst_n=0, immediately force count=0, out_valid_o=0, fetch_addr_o={RESET_PC[31:2],2'b00}, out_pc_o={RESET_PC[31:1],1'b0}, drop_lo=RESET_PC[1].
REQ-029 SHALL drive imem_ready_o=1 on the first rising edge after rst_n deasserts.
REQ-030 SHALL discard buffer contents on reset mid-operation; halfword data registers need no reset.

Verification
REQ-031 SHALL cover: RESET_PC=0, word 0x00130513 -> out_inst_o=0x00130513, out_pc_o=0, out_is_comp_o=0; fetch_addr_o=4.
REQ-032 SHALL cover: word 0x45014505 -> 0x00004505 @pc 0 comp=1, then 0x00004501 @pc 2 comp=1.
REQ-033 SHALL cover straddle: words 0x05130001, 0x00010013 -> 0x00000001 @0, 0x00130513 @2, 0x00000001 @6.
REQ-034 SHALL cover flush_pc_i=0x102 -> fetch_addr_o=0x100, word 0x4505ABCD gives 0x00004505 @0x102; 0xABCD never output.
REQ-035 SHALL cover out_ready_i=0 for 5 cycles with imem_valid_i=1 -> imem_ready_o=0 once count>=2, out_inst_o stable, all halfwords later emitted in order.
REQ-036 SHALL cover rst_n pulsed low at count=2 -> out_valid_o=0 same cycle, fetch_addr_o=RESET_PC, no stale output after release.
